// File: rtl/pic_pkg.sv
// Shared types and bit positions for the 8259A read/write control and command decode.
package pic_pkg;

    typedef enum logic [2:0] {
        WAIT_ICW1 = 3'd0,
        WAIT_ICW2 = 3'd1,
        WAIT_ICW3 = 3'd2,
        WAIT_ICW4 = 3'd3,
        READY     = 3'd4
    } init_state_t;

    localparam logic [2:0] RD_NONE = 3'd0;
    localparam logic [2:0] RD_IRR  = 3'd1;
    localparam logic [2:0] RD_ISR  = 3'd2;
    localparam logic [2:0] RD_IMR  = 3'd3;
    localparam logic [2:0] RD_POLL = 3'd4;

    localparam int ICW1_IC4  = 0;
    localparam int ICW1_SNGL = 1;
    localparam int ICW1_LTIM = 3;
    localparam int ICW1_SEL  = 4;

    localparam int ICW4_UPM  = 0;
    localparam int ICW4_AEOI = 1;
    localparam int ICW4_MS   = 2;
    localparam int ICW4_BUF  = 3;
    localparam int ICW4_SFNM = 4;

    localparam int OCW_SEL3  = 3;
    localparam int OCW3_RIS  = 0;
    localparam int OCW3_RR   = 1;
    localparam int OCW3_P    = 2;
    localparam int OCW3_SMM  = 5;
    localparam int OCW3_ESMM = 6;

    function automatic logic is_icw1(input logic a0, input logic [7:0] d);
        return !a0 && d[ICW1_SEL];
    endfunction

endpackage

// File: rtl/pic_bus_sampler.sv
// Qualifies CPU strobes, captures write bytes, pulses decode when wr_n returns high.
// buf_en/buf_dir registered one cycle after strobes; no backpressure, CPU timing is absolute.
module pic_bus_sampler
    import pic_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       a0,
    input  logic [7:0] din,
    output logic [7:0] cap_dat,
    output logic       cap_a0,
    output logic       dec_vld,
    output logic       rd_acc,
    output logic       rd_end,
    output logic       buf_en,
    output logic       buf_dir
);

    logic wr_acc;
    logic illegal;
    logic wr_pend;
    logic rd_act;

    assign wr_acc  = !cs_n && !wr_n && rd_n;
    assign rd_acc  = !cs_n && !rd_n && wr_n;
    assign illegal = !rd_n && !wr_n;
    assign dec_vld = wr_pend && wr_n;
    assign rd_end  = rd_act && rd_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_dat <= 8'h00;
            cap_a0  <= 1'b0;
            wr_pend <= 1'b0;
            rd_act  <= 1'b0;
            buf_en  <= 1'b0;
            buf_dir <= 1'b0;
        end else begin
            buf_en  <= wr_acc || rd_acc;
            buf_dir <= rd_acc;
            if (wr_acc) begin
                cap_dat <= din;
                cap_a0  <= a0;
            end
            // A write cut short by cs_n or a clashing rd_n is dropped, never decoded.
            if (dec_vld)
                wr_pend <= 1'b0;
            else if (wr_acc)
                wr_pend <= 1'b1;
            else if (cs_n || illegal)
                wr_pend <= wr_n ? wr_pend : 1'b0;
            if (rd_acc)
                rd_act <= 1'b1;
            else if (rd_n)
                rd_act <= 1'b0;
        end
    end

endmodule

// File: rtl/rw_control_logic.sv
// 8259A read/write control: ICW1-4 init FSM and OCW1-3 command registers.
// Decoded values visible the cycle after wr_n is sampled high; strobes are single-cycle, no backpressure.
module rw_control_logic
    import pic_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       a0,
    input  logic [7:0] din,
    output logic       buf_en,
    output logic       buf_dir,
    output logic [2:0] rd_sel,
    output logic       init_done,
    output logic       icw1_stb,
    output logic       ic4,
    output logic       sngl,
    output logic       ltim,
    output logic [4:0] vec_base,
    output logic [7:0] icw3,
    output logic       upm,
    output logic       aeoi,
    output logic       ms,
    output logic       buf_mode,
    output logic       sfnm,
    output logic [7:0] imr,
    output logic       ocw2_stb,
    output logic [2:0] ocw2_cmd,
    output logic [2:0] ocw2_lvl,
    output logic       smm,
    output logic       poll_stb
);

    logic [7:0]  cap_dat;
    logic        cap_a0;
    logic        dec_vld;
    logic        rd_acc;
    logic        rd_end;
    logic        ris;
    logic        poll_pend;
    logic        poll_rd;
    init_state_t state, state_nxt;

    pic_bus_sampler u_sampler (
        .clk     (clk),
        .rst     (rst),
        .cs_n    (cs_n),
        .rd_n    (rd_n),
        .wr_n    (wr_n),
        .a0      (a0),
        .din     (din),
        .cap_dat (cap_dat),
        .cap_a0  (cap_a0),
        .dec_vld (dec_vld),
        .rd_acc  (rd_acc),
        .rd_end  (rd_end),
        .buf_en  (buf_en),
        .buf_dir (buf_dir)
    );

    logic icw1_hit, icw2_hit, icw3_hit, icw4_hit, ocw1_hit, ocw2_hit, ocw3_hit;

    assign icw1_hit = dec_vld && is_icw1(cap_a0, cap_dat);
    assign icw2_hit = dec_vld && cap_a0 && (state == WAIT_ICW2);
    assign icw3_hit = dec_vld && cap_a0 && (state == WAIT_ICW3);
    assign icw4_hit = dec_vld && cap_a0 && (state == WAIT_ICW4);
    assign ocw1_hit = dec_vld && cap_a0 && (state == READY);
    assign ocw2_hit = dec_vld && !cap_a0 && !cap_dat[ICW1_SEL] && !cap_dat[OCW_SEL3] && (state == READY);
    assign ocw3_hit = dec_vld && !cap_a0 && !cap_dat[ICW1_SEL] &&  cap_dat[OCW_SEL3] && (state == READY);

    always_ff @(posedge clk) begin
        if (rst)
            state <= WAIT_ICW1;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (icw1_hit)
            state_nxt = WAIT_ICW2;
        else if (icw2_hit)
            state_nxt = !sngl ? WAIT_ICW3 : (ic4 ? WAIT_ICW4 : READY);
        else if (icw3_hit)
            state_nxt = ic4 ? WAIT_ICW4 : READY;
        else if (icw4_hit)
            state_nxt = READY;
    end

    always_comb begin
        init_done = (state == READY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            icw1_stb  <= 1'b0;
            ocw2_stb  <= 1'b0;
            poll_stb  <= 1'b0;
            ic4       <= 1'b0;
            sngl      <= 1'b0;
            ltim      <= 1'b0;
            vec_base  <= 5'd0;
            icw3      <= 8'h00;
            upm       <= 1'b0;
            aeoi      <= 1'b0;
            ms        <= 1'b0;
            buf_mode  <= 1'b0;
            sfnm      <= 1'b0;
            imr       <= 8'hFF;
            ocw2_cmd  <= 3'd0;
            ocw2_lvl  <= 3'd0;
            smm       <= 1'b0;
            ris       <= 1'b0;
            poll_pend <= 1'b0;
            poll_rd   <= 1'b0;
            rd_sel    <= RD_NONE;
        end else begin
            icw1_stb <= icw1_hit;
            ocw2_stb <= ocw2_hit;
            poll_stb <= ocw3_hit && cap_dat[OCW3_P];

            if (icw1_hit) begin
                ic4      <= cap_dat[ICW1_IC4];
                sngl     <= cap_dat[ICW1_SNGL];
                ltim     <= cap_dat[ICW1_LTIM];
                imr      <= 8'h00;
                smm      <= 1'b0;
                aeoi     <= 1'b0;
                upm      <= 1'b0;
                sfnm     <= 1'b0;
                buf_mode <= 1'b0;
                ms       <= 1'b0;
                ris      <= 1'b0;
            end
            if (icw2_hit)
                vec_base <= cap_dat[7:3];
            if (icw3_hit)
                icw3 <= cap_dat;
            if (icw4_hit) begin
                upm      <= cap_dat[ICW4_UPM];
                aeoi     <= cap_dat[ICW4_AEOI];
                ms       <= cap_dat[ICW4_MS];
                buf_mode <= cap_dat[ICW4_BUF];
                sfnm     <= cap_dat[ICW4_SFNM];
            end
            if (ocw1_hit)
                imr <= cap_dat;
            if (ocw2_hit) begin
                ocw2_cmd <= cap_dat[7:5];
                ocw2_lvl <= cap_dat[2:0];
            end
            if (ocw3_hit && cap_dat[OCW3_ESMM])
                smm <= cap_dat[OCW3_SMM];
            if (ocw3_hit && cap_dat[OCW3_RR])
                ris <= cap_dat[OCW3_RIS];

            // Poll stays pending until a read that actually returned the poll word ends.
            if (icw1_hit)
                poll_pend <= 1'b0;
            else if (ocw3_hit && cap_dat[OCW3_P])
                poll_pend <= 1'b1;
            else if (rd_end && poll_rd)
                poll_pend <= 1'b0;

            if (icw1_hit)
                poll_rd <= 1'b0;
            else if (rd_acc && !a0 && poll_pend)
                poll_rd <= 1'b1;
            else if (rd_end)
                poll_rd <= 1'b0;

            if (!rd_acc)
                rd_sel <= RD_NONE;
            else if (a0)
                rd_sel <= RD_IMR;
            else if (poll_pend)
                rd_sel <= RD_POLL;
            else
                rd_sel <= ris ? RD_ISR : RD_IRR;
        end
    end

endmodule

// File: tb/tb_rw_control_logic.sv
// Directed plus randomized bus transactions checked against a transaction-level model of the PIC command decode.
module tb_rw_control_logic;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs_n, rd_n, wr_n, a0;
    logic [7:0] din;
    logic       buf_en, buf_dir;
    logic [2:0] rd_sel;
    logic       init_done, icw1_stb, ic4, sngl, ltim;
    logic [4:0] vec_base;
    logic [7:0] icw3;
    logic       upm, aeoi, ms, buf_mode, sfnm;
    logic [7:0] imr;
    logic       ocw2_stb;
    logic [2:0] ocw2_cmd, ocw2_lvl;
    logic       smm, poll_stb;

    rw_control_logic dut (
        .clk(clk), .rst(rst), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a0(a0), .din(din),
        .buf_en(buf_en), .buf_dir(buf_dir), .rd_sel(rd_sel), .init_done(init_done),
        .icw1_stb(icw1_stb), .ic4(ic4), .sngl(sngl), .ltim(ltim), .vec_base(vec_base),
        .icw3(icw3), .upm(upm), .aeoi(aeoi), .ms(ms), .buf_mode(buf_mode), .sfnm(sfnm),
        .imr(imr), .ocw2_stb(ocw2_stb), .ocw2_cmd(ocw2_cmd), .ocw2_lvl(ocw2_lvl),
        .smm(smm), .poll_stb(poll_stb)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: init progress as a step count 0..4 (4 = operational).
    int         m_step;
    logic       m_ic4, m_sngl, m_ltim, m_upm, m_aeoi, m_ms, m_buf, m_sfnm, m_smm;
    logic [7:0] m_vec, m_icw3, m_imr;
    logic [2:0] m_cmd, m_lvl;
    logic       m_isr_sel, m_poll;
    int         x_icw1 = 0, x_ocw2 = 0, x_poll = 0;
    int         n_icw1 = 0, n_ocw2 = 0, n_poll = 0;

    always @(negedge clk) begin
        if (icw1_stb) n_icw1++;
        if (ocw2_stb) n_ocw2++;
        if (poll_stb) n_poll++;
    end

    task automatic model_reset();
        m_step = 0;
        {m_ic4, m_sngl, m_ltim, m_upm, m_aeoi, m_ms, m_buf, m_sfnm, m_smm} = '0;
        m_vec = 0; m_icw3 = 0; m_imr = 8'hFF; m_cmd = 0; m_lvl = 0;
        m_isr_sel = 0; m_poll = 0;
    endtask

    task automatic model_write(input logic wa0, input logic [7:0] d);
        if (!wa0 && d[4]) begin
            m_ic4 = d[0]; m_sngl = d[1]; m_ltim = d[3];
            m_imr = 8'h00; m_smm = 0; m_aeoi = 0; m_upm = 0; m_sfnm = 0; m_buf = 0; m_ms = 0;
            m_isr_sel = 0; m_poll = 0; x_icw1++; m_step = 1;
        end else if (m_step == 1 && wa0) begin
            m_vec = {3'b000, d[7:3]};
            m_step = !m_sngl ? 2 : (m_ic4 ? 3 : 4);
        end else if (m_step == 2 && wa0) begin
            m_icw3 = d;
            m_step = m_ic4 ? 3 : 4;
        end else if (m_step == 3 && wa0) begin
            {m_sfnm, m_buf, m_ms, m_aeoi, m_upm} = d[4:0];
            m_step = 4;
        end else if (m_step == 4) begin
            if (wa0) m_imr = d;
            else if (!d[3]) begin
                m_cmd = d[7:5]; m_lvl = d[2:0]; x_ocw2++;
            end else begin
                if (d[6]) m_smm = d[5];
                if (d[1]) m_isr_sel = d[0];
                if (d[2]) begin m_poll = 1; x_poll++; end
            end
        end
    endtask

    task automatic check_all();
        check("init_done", 32'(init_done), 32'(m_step == 4));
        check("ic4", 32'(ic4), 32'(m_ic4));
        check("sngl", 32'(sngl), 32'(m_sngl));
        check("ltim", 32'(ltim), 32'(m_ltim));
        check("vec_base", 32'(vec_base), 32'(m_vec));
        check("icw3", 32'(icw3), 32'(m_icw3));
        check("icw4", 32'({sfnm, buf_mode, ms, aeoi, upm}), 32'({m_sfnm, m_buf, m_ms, m_aeoi, m_upm}));
        check("imr", 32'(imr), 32'(m_imr));
        check("smm", 32'(smm), 32'(m_smm));
        check("ocw2_cmd", 32'(ocw2_cmd), 32'(m_cmd));
        check("ocw2_lvl", 32'(ocw2_lvl), 32'(m_lvl));
        check("icw1_stb_cnt", n_icw1, x_icw1);
        check("ocw2_stb_cnt", n_ocw2, x_ocw2);
        check("poll_stb_cnt", n_poll, x_poll);
    endtask

    task automatic settle();
        @(negedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic bus_write(input logic wa0, input logic [7:0] d);
        @(negedge clk);
        cs_n = 0; wr_n = 0; a0 = wa0; din = d;
        @(negedge clk);
        check("wr_buf_en", 32'(buf_en), 32'd1);
        check("wr_buf_dir", 32'(buf_dir), 32'd0);
        check("wr_rd_sel", 32'(rd_sel), 32'd0);
        @(negedge clk);
        wr_n = 1; cs_n = 1; din = $urandom;
        @(negedge clk);
        model_write(wa0, d);
    endtask

    task automatic bus_read(input logic ra0);
        logic [2:0] exp;
        logic       took_poll;
        exp = ra0 ? 3'd3 : (m_poll ? 3'd4 : (m_isr_sel ? 3'd2 : 3'd1));
        took_poll = !ra0 && m_poll;
        @(negedge clk);
        cs_n = 0; rd_n = 0; a0 = ra0;
        @(negedge clk);
        check("rd_sel", 32'(rd_sel), 32'(exp));
        check("rd_buf_en", 32'(buf_en), 32'd1);
        check("rd_buf_dir", 32'(buf_dir), 32'd1);
        @(negedge clk);
        rd_n = 1; cs_n = 1;
        @(negedge clk);
        check("rd_sel_idle", 32'(rd_sel), 32'd0);
        check("rd_buf_idle", 32'({buf_en, buf_dir}), 32'd0);
        if (took_poll) m_poll = 0;
    endtask

    task automatic bus_abort(input logic [7:0] d);
        @(negedge clk);
        cs_n = 0; wr_n = 0; a0 = $urandom_range(0, 1); din = d;
        @(negedge clk);
        cs_n = 1;
        @(negedge clk);
        wr_n = 1;
        settle();
    endtask

    task automatic bus_illegal(input logic [7:0] d);
        @(negedge clk);
        cs_n = 0; wr_n = 0; a0 = $urandom_range(0, 1); din = d;
        @(negedge clk);
        rd_n = 0;
        @(negedge clk);
        check("illegal_buf_en", 32'(buf_en), 32'd0);
        rd_n = 1; wr_n = 1; cs_n = 1;
        settle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        logic       wa;
        int         r;
        rst = 1; cs_n = 1; rd_n = 1; wr_n = 1; a0 = 0; din = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 0;
        check("rst_imr", 32'(imr), 32'hFF);
        check("rst_rd_sel", 32'(rd_sel), 32'd0);
        check("rst_bus", 32'({buf_en, buf_dir}), 32'd0);
        check_all();

        // Full ICW sequence with ICW3 and ICW4.
        bus_write(0, 8'h11); bus_write(1, 8'h08); bus_write(1, 8'h04);
        check("pre_icw4_init_done", 32'(init_done), 32'd0);
        bus_write(1, 8'h01);
        settle();
        check("seq_vec_base", 32'(vec_base), 32'h01);
        check("seq_upm", 32'(upm), 32'd1);

        // Single mode without ICW4, then IMR write.
        bus_write(0, 8'h12); bus_write(1, 8'h20);
        settle();
        check("single_ready", 32'(init_done), 32'd1);
        bus_write(1, 8'hA5);
        settle();
        check("single_imr", 32'(imr), 32'hA5);

        // OCW2, OCW3 read select, poll.
        bus_write(0, 8'h63);
        settle();
        check("ocw2_cmd_dir", 32'(ocw2_cmd), 32'd3);
        bus_write(0, 8'h0B);
        settle();
        bus_read(0);
        bus_write(0, 8'h0C);
        settle();
        bus_read(1);
        bus_read(0);
        bus_read(0);

        // Back-to-back writes with minimal gap.
        bus_write(0, 8'h40); bus_write(1, 8'h3C); bus_write(0, 8'h0C);
        settle();

        bus_abort(8'h00);
        bus_illegal(8'h5A);

        // Reset partway through initialization.
        bus_write(0, 8'h11); bus_write(1, 8'h08);
        @(negedge clk);
        cs_n = 0; wr_n = 0; a0 = 1; din = 8'h04;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0; wr_n = 1; cs_n = 1;
        model_reset();
        settle();
        check("midrst_imr", 32'(imr), 32'hFF);
        bus_write(1, 8'h55);
        settle();

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 19);
            d = 8'($urandom);
            wa = 1'($urandom_range(0, 1));
            if (r < 9) begin
                bus_write(wa, d); settle();
            end else if (r < 13) begin
                bus_read(wa);
            end else if (r < 15) begin
                bus_write(1, d); settle();
            end else if (r < 17) begin
                bus_abort(d);
            end else if (r < 19) begin
                bus_illegal(d);
            end else begin
                do_reset(); settle();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
